// File: rtl/board_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : board_display_scanner
// Description : Double-buffered 16x16 LED row scanner with a 4-digit hex
//               7-segment display of the generation count.
// Revision    : 1.0 - initial release
// ============================================================================
module board_display_scanner #(
    parameter int ROW_DIV   = 50000,
    parameter int DIGIT_DIV = 100000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] board_i,
    input  logic [15:0]  gen_cnt_i,
    input  logic         load_valid_i,
    output logic         load_ready_o,
    output logic [15:0]  row_sel_o,
    output logic [15:0]  col_o,
    output logic         frame_done_o,
    output logic [6:0]   seg_o,
    output logic [3:0]   an_o
);

    localparam int c_row_cw   = $clog2(ROW_DIV);
    localparam int c_digit_cw = (DIGIT_DIV > 1) ? $clog2(DIGIT_DIV) : 1;
    localparam logic [c_row_cw-1:0]   c_row_last   = c_row_cw'(ROW_DIV - 1);
    localparam logic [c_digit_cw-1:0] c_digit_last = c_digit_cw'(DIGIT_DIV - 1);

    logic [c_row_cw-1:0]   row_cnt_q, row_cnt_d;
    logic [3:0]            row_q, row_d;
    logic [c_digit_cw-1:0] digit_cnt_q, digit_cnt_d;
    logic [1:0]            digit_q, digit_d;
    logic [255:0]          active_q, active_d, shadow_q, shadow_d;
    logic [15:0]           active_cnt_q, active_cnt_d, shadow_cnt_q, shadow_cnt_d;
    logic                  shadow_full_q, shadow_full_d;
    logic                  ready_d;
    logic [15:0]           row_sel_d, col_d;
    logic                  frame_done_d;
    logic [6:0]            seg_d;
    logic [3:0]            an_d;
    logic                  frame_end;
    logic                  load_fire;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        case (nib)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign frame_end = (row_q == 4'd15) && (row_cnt_q == c_row_last);
    assign load_fire = load_valid_i && load_ready_o;

    always_comb begin
        row_cnt_d     = row_cnt_q + 1'b1;
        row_d         = row_q;
        digit_cnt_d   = digit_cnt_q + 1'b1;
        digit_d       = digit_q;
        active_d      = active_q;
        active_cnt_d  = active_cnt_q;
        shadow_d      = shadow_q;
        shadow_cnt_d  = shadow_cnt_q;
        shadow_full_d = shadow_full_q;

        if (row_cnt_q == c_row_last) begin
            row_cnt_d = '0;
            row_d     = row_q + 4'd1;
        end
        if (digit_cnt_q == c_digit_last) begin
            digit_cnt_d = '0;
            digit_d     = digit_q + 2'd1;
        end

        // Swap and fill are mutually exclusive: swap needs a full shadow, fill an empty one.
        if (frame_end && shadow_full_q) begin
            active_d      = shadow_q;
            active_cnt_d  = shadow_cnt_q;
            shadow_full_d = 1'b0;
        end
        if (load_fire) begin
            shadow_d      = board_i;
            shadow_cnt_d  = gen_cnt_i;
            shadow_full_d = 1'b1;
        end

        // Outputs are registered images of the state entering the next cycle.
        ready_d      = ~shadow_full_d;
        row_sel_d    = 16'h0001 << row_d;
        col_d        = (row_cnt_d == '0) ? 16'h0000 : active_d[{row_d, 4'b0000} +: 16];
        frame_done_d = (row_d == 4'd15) && (row_cnt_d == c_row_last);
        an_d         = ~(4'b0001 << digit_d);
        seg_d        = hex7(active_cnt_d[{digit_d, 2'b00} +: 4]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            row_cnt_q     <= '0;
            row_q         <= '0;
            digit_cnt_q   <= '0;
            digit_q       <= '0;
            active_q      <= '0;
            active_cnt_q  <= '0;
            shadow_q      <= '0;
            shadow_cnt_q  <= '0;
            shadow_full_q <= 1'b0;
            load_ready_o  <= 1'b0;
            row_sel_o     <= 16'h0001;
            col_o         <= 16'h0000;
            frame_done_o  <= 1'b0;
            an_o          <= 4'b1110;
            seg_o         <= 7'b1000000;
        end else begin
            row_cnt_q     <= row_cnt_d;
            row_q         <= row_d;
            digit_cnt_q   <= digit_cnt_d;
            digit_q       <= digit_d;
            active_q      <= active_d;
            active_cnt_q  <= active_cnt_d;
            shadow_q      <= shadow_d;
            shadow_cnt_q  <= shadow_cnt_d;
            shadow_full_q <= shadow_full_d;
            load_ready_o  <= ready_d;
            row_sel_o     <= row_sel_d;
            col_o         <= col_d;
            frame_done_o  <= frame_done_d;
            an_o          <= an_d;
            seg_o         <= seg_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_board_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_display_scanner
// Description : Directed self-checking bench with a cycle-count based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_display_scanner;

    localparam int ROW_DIV   = 4;
    localparam int DIGIT_DIV = 8;
    localparam int FRAME     = 16 * ROW_DIV;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] board_i;
    logic [15:0]  gen_cnt_i;
    logic         load_valid_i;
    logic         load_ready_o;
    logic [15:0]  row_sel_o;
    logic [15:0]  col_o;
    logic         frame_done_o;
    logic [6:0]   seg_o;
    logic [3:0]   an_o;

    int n_checks = 0;
    int n_errors = 0;

    board_display_scanner #(.ROW_DIV(ROW_DIV), .DIGIT_DIV(DIGIT_DIV)) dut (
        .clk          (clk),
        .reset        (reset),
        .board_i      (board_i),
        .gen_cnt_i    (gen_cnt_i),
        .load_valid_i (load_valid_i),
        .load_ready_o (load_ready_o),
        .row_sel_o    (row_sel_o),
        .col_o        (col_o),
        .frame_done_o (frame_done_o),
        .seg_o        (seg_o),
        .an_o         (an_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[n];
    endfunction

    // Model: everything follows from the cycle count since the last reset edge.
    logic [255:0] m_active, m_shadow;
    logic [15:0]  m_cnt, m_scnt;
    bit           m_full, m_ready, m_valid = 1'b0, m_fire;
    int           tick;

    always @(posedge clk) begin
        if (!reset) begin
            m_active = '0; m_cnt = '0; m_full = 1'b0; m_ready = 1'b0;
            tick = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            m_fire = load_valid_i && m_ready;
            if ((tick % FRAME) == FRAME - 1 && m_full) begin
                m_active = m_shadow; m_cnt = m_scnt; m_full = 1'b0;
            end
            if (m_fire) begin
                m_shadow = board_i; m_scnt = gen_cnt_i; m_full = 1'b1;
            end
            m_ready = !m_full;
            tick++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            int row, rc, dg;
            logic [15:0] ecol;
            row  = (tick / ROW_DIV) % 16;
            rc   = tick % ROW_DIV;
            dg   = (tick / DIGIT_DIV) % 4;
            ecol = (rc == 0) ? 16'h0000 : m_active[row*16 +: 16];
            check("m_ready",   {31'd0, load_ready_o}, {31'd0, m_ready});
            check("m_row_sel", {16'd0, row_sel_o}, 32'd1 << row);
            check("m_col",     {16'd0, col_o}, {16'd0, ecol});
            check("m_frame",   {31'd0, frame_done_o}, (row == 15 && rc == ROW_DIV - 1) ? 32'd1 : 32'd0);
            check("m_an",      {28'd0, an_o}, {28'd0, ~(4'b0001 << dg)});
            check("m_seg",     {25'd0, seg_o}, {25'd0, seg_of(m_cnt[dg*4 +: 4])});
        end
    end

    // which: 0 frame_done, 1 row_sel, 2 an, 3 ready
    task automatic wait_sig(input string name, input int which, input logic [15:0] val, input int limit);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            @(negedge clk);
            case (which)
                0: hit = (frame_done_o === 1'b1);
                1: hit = (row_sel_o === val);
                2: hit = (an_o === val[3:0]);
                default: hit = (load_ready_o === 1'b1);
            endcase
        end
        if (!hit) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_%s: timed out after %0d cycles", name, limit);
        end
    endtask

    initial begin
        int n;
        logic [255:0] b;
        reset = 1'b0; load_valid_i = 1'b0; board_i = '0; gen_cnt_i = '0;

        repeat (3) @(negedge clk);
        check("rst_row_sel", {16'd0, row_sel_o}, 32'h0001);
        check("rst_col",     {16'd0, col_o}, 32'h0000);
        check("rst_an",      {28'd0, an_o}, 32'b1110);
        check("rst_seg",     {25'd0, seg_o}, 32'b1000000);
        check("rst_ready",   {31'd0, load_ready_o}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_rel", {31'd0, load_ready_o}, 32'd1);

        // Mid-frame load
        repeat (10) @(negedge clk);
        b = '0; b[0] = 1'b1; b[255] = 1'b1;
        board_i = b; gen_cnt_i = 16'hA5C3; load_valid_i = 1'b1;
        @(negedge clk);
        load_valid_i = 1'b0; board_i = '1; gen_cnt_i = 16'hFFFF;
        check("ready_drop", {31'd0, load_ready_o}, 32'd0);
        wait_sig("fd1", 0, 16'h0, 200);
        @(negedge clk);
        check("row0_blank", {16'd0, col_o}, 32'h0000);
        @(negedge clk);
        check("row0_col", {16'd0, col_o}, 32'h0001);
        wait_sig("row15", 1, 16'h8000, 100);
        @(negedge clk);
        check("row15_col", {16'd0, col_o}, 32'h8000);
        wait_sig("fd2", 0, 16'h0, 100);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done_o !== 1'b1 && n < 200);
        check("frame_period", n, FRAME);

        // Digit scan of A5C3
        wait_sig("an0", 2, 16'b1110, 40);
        check("seg_d0", {25'd0, seg_o}, 32'b0110000);
        wait_sig("an1", 2, 16'b1101, 40);
        check("seg_d1", {25'd0, seg_o}, 32'b1000110);
        wait_sig("an2", 2, 16'b1011, 40);
        check("seg_d2", {25'd0, seg_o}, 32'b0010010);
        wait_sig("an3", 2, 16'b0111, 40);
        check("seg_d3", {25'd0, seg_o}, 32'b0001000);

        // Second offer while shadow full
        b = '0; b[17] = 1'b1;
        board_i = b; gen_cnt_i = 16'h0001; load_valid_i = 1'b1;
        @(negedge clk);
        b = '0; b[34] = 1'b1;
        board_i = b; gen_cnt_i = 16'h0002;
        check("ready_full", {31'd0, load_ready_o}, 32'd0);
        wait_sig("ready_swap", 3, 16'h0, 200);
        @(negedge clk);
        load_valid_i = 1'b0;
        check("ready_refill", {31'd0, load_ready_o}, 32'd0);
        wait_sig("fd3", 0, 16'h0, 100);
        wait_sig("row2", 1, 16'h0004, 20);
        @(negedge clk);
        check("board3_col", {16'd0, col_o}, 32'h0004);

        // Offer exactly on the frame-end cycle
        wait_sig("fd4", 0, 16'h0, 100);
        b = '0; b[51] = 1'b1;
        board_i = b; gen_cnt_i = 16'h0BEE; load_valid_i = 1'b1;
        @(negedge clk);
        load_valid_i = 1'b0;
        check("ready_fe", {31'd0, load_ready_o}, 32'd0);
        wait_sig("row2b", 1, 16'h0004, 20);
        @(negedge clk);
        check("old_persists", {16'd0, col_o}, 32'h0004);
        wait_sig("fd5", 0, 16'h0, 100);
        wait_sig("row3", 1, 16'h0008, 20);
        @(negedge clk);
        check("board4_col", {16'd0, col_o}, 32'h0008);

        // Reset at row 7 with shadow full
        board_i = '1; gen_cnt_i = 16'hFFFF; load_valid_i = 1'b1;
        @(negedge clk);
        load_valid_i = 1'b0;
        wait_sig("row7", 1, 16'h0080, 100);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("rst2_row_sel", {16'd0, row_sel_o}, 32'h0001);
        check("rst2_seg",     {25'd0, seg_o}, 32'b1000000);
        repeat (2) @(negedge clk);
        check("rst2_col", {16'd0, col_o}, 32'h0000);
        check("rst2_ready", {31'd0, load_ready_o}, 32'd1);
        repeat (FRAME + 8) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
